// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clock-divider bank.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clk_gen_pkg;

  localparam int DIVW_DEF = 16;
  localparam int DIV_MIN  = 2;

  // Config slot state: a single request may be outstanding at a time.
  typedef enum logic {
    CFG_IDLE    = 1'b0,
    CFG_PENDING = 1'b1
  } cfg_state_e;

  // Divisors below DIV_MIN cannot produce a two-phase clock; force them up.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

  // Bits needed to hold a counter that saturates at 'cycles'.
  function automatic int lock_cnt_w(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, ~50% duty registered clock, wrap strobe, divisor load.
// Latency: clk_out_o registered from next count; tick_o combinational from count; load takes effect at wrap.
// Backpressure: ld_i is held by the owner until ld_done_o (wrap, or immediately when disabled).
// Ports: clk_i/areset_i clock+reset, en_i run enable, ld_i/ld_div_i load request,
//        clk_out_o divided clock, tick_o wrap strobe, ld_done_o one-cycle load acknowledge.
module clk_div_chan
  import clk_gen_pkg::*;
#(
  parameter int DIVW        = DIVW_DEF,
  parameter int DEFAULT_DIV = 2
) (
  input  logic            clk_i,
  input  logic            areset_i,
  input  logic            en_i,
  input  logic            ld_i,
  input  logic [DIVW-1:0] ld_div_i,
  output logic            clk_out_o,
  output logic            tick_o,
  output logic            ld_done_o
);

  localparam logic [DIVW-1:0] ONE = DIVW'(1);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [DIVW-1:0] half_d;
  logic            clk_q, clk_d;
  logic            run_q;
  logic            wrap;
  logic [DIVW-1:0] ld_div_clamped;

  assign ld_div_clamped = DIVW'(clamp_div(32'(ld_div_i)));

  // run_q marks that the previous cycle was enabled; the first enabled cycle
  // only restarts the count so the first high phase is full length.
  assign wrap = run_q && (cnt_q == div_q - ONE);

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    ld_done_o = 1'b0;
    if (!en_i) begin
      cnt_d = '0;
      if (ld_i) begin
        div_d     = ld_div_clamped;
        ld_done_o = 1'b1;
      end
    end else if (!run_q) begin
      cnt_d = '0;
    end else if (wrap) begin
      // Switching only at a wrap keeps both old and new phases whole.
      cnt_d = '0;
      if (ld_i) begin
        div_d     = ld_div_clamped;
        ld_done_o = 1'b1;
      end
    end else begin
      cnt_d = cnt_q + ONE;
    end
    // High for ceil(div/2) counts, low for the rest.
    half_d = (div_d >> 1) + {{(DIVW-1){1'b0}}, div_d[0]};
    clk_d  = en_i && (cnt_d < half_d);
  end

  always_ff @(posedge clk_i or posedge areset_i) begin
    if (areset_i) begin
      cnt_q <= '0;
      div_q <= DIVW'(DEFAULT_DIV);
      clk_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
      clk_q <= clk_d;
      run_q <= en_i;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = en_i && wrap;

endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-divider bank with single-slot config and lock indicator.
// Latency: config applied at the target channel's next wrap (next cycle if disabled); locked LOCK_CYCLES after.
// Backpressure: cfg_ready low while a config is pending; out-of-range channel requests are accepted and dropped.
// Ports: clk/areset, cfg_valid/cfg_ready/cfg_ch/cfg_div config handshake, ch_en per-channel enable,
//        clk_out divided clocks, tick wrap strobes, locked all-channels-stable flag.
module clk_div_bank
  import clk_gen_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int DIVW        = DIVW_DEF,
  parameter int DEFAULT_DIV = 2,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [$clog2(NCH):0] cfg_ch,
  input  logic [DIVW-1:0]      cfg_div,
  input  logic [NCH-1:0]       ch_en,
  output logic [NCH-1:0]       clk_out,
  output logic [NCH-1:0]       tick,
  output logic                 locked
);

  localparam int              CHW      = $clog2(NCH) + 1;
  localparam int              LCW      = lock_cnt_w(LOCK_CYCLES);
  localparam logic [LCW-1:0]  LOCK_MAX = LCW'(LOCK_CYCLES);
  localparam logic [CHW-1:0]  NCH_C    = CHW'(NCH);

  cfg_state_e      state_q;
  logic [CHW-1:0]  pend_ch_q;
  logic [DIVW-1:0] pend_div_q;
  logic [LCW-1:0]  lock_cnt_q;
  logic [LCW-1:0]  lock_inc;
  logic            locked_q;
  logic            ch_ok;
  logic [NCH-1:0]  ld;
  logic [NCH-1:0]  ld_done;

  assign ch_ok    = cfg_ch < NCH_C;
  assign lock_inc = (lock_cnt_q == LOCK_MAX) ? lock_cnt_q : lock_cnt_q + LCW'(1);

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= CFG_IDLE;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
      lock_cnt_q <= '0;
      locked_q   <= 1'b0;
    end else begin
      case (state_q)
        CFG_IDLE: begin
          if (cfg_valid && ch_ok) begin
            pend_ch_q  <= cfg_ch;
            pend_div_q <= cfg_div;
            state_q    <= CFG_PENDING;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
          end else begin
            // Out-of-range requests complete here without touching the lock.
            lock_cnt_q <= lock_inc;
            locked_q   <= (lock_inc == LOCK_MAX);
          end
        end
        CFG_PENDING: begin
          lock_cnt_q <= '0;
          locked_q   <= 1'b0;
          if (|ld_done) state_q <= CFG_IDLE;
        end
        default: state_q <= CFG_IDLE;
      endcase
    end
  end

  assign cfg_ready = (state_q == CFG_IDLE);
  assign locked    = locked_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    assign ld[i] = (state_q == CFG_PENDING) && (pend_ch_q == CHW'(i));

    clk_div_chan #(
      .DIVW        (DIVW),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_i     (clk),
      .areset_i  (areset),
      .en_i      (ch_en[i]),
      .ld_i      (ld[i]),
      .ld_div_i  (pend_div_q),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i]),
      .ld_done_o (ld_done[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: defaults, per-channel ratios, handshake and lock behaviour.
// Latency: n/a.
// Backpressure: n/a.
module tb_clk_div_bank;

  logic        clk;
  logic        areset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [2:0]  cfg_ch;
  logic [15:0] cfg_div;
  logic [3:0]  ch_en;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic        locked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int ch;
    int dv;
    int exp_hi;
    int exp_lo;
  } vec_t;

  typedef struct {
    int ch;
    int hi;
    int lo;
  } exp_t;

  vec_t vecs[5];
  exp_t sb[$];

  clk_div_bank dut (
    .clk       (clk),
    .areset    (areset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .ch_en     (ch_en),
    .clk_out   (clk_out),
    .tick      (tick),
    .locked    (locked)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event required event", name);
  endtask

  // Drive a request from a negedge; returns at the negedge after the transfer.
  task automatic do_cfg(input int ch, input int dv, output int stall);
    stall     = 0;
    cfg_valid = 1'b1;
    cfg_ch    = 3'(ch);
    cfg_div   = 16'(dv);
    while (!cfg_ready && stall < 200) begin
      @(negedge clk);
      stall++;
    end
    if (stall >= 200) timeout("cfg_accept");
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cfg_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) timeout("cfg_ready_return");
  endtask

  task automatic count_to_lock(output int n);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (locked) break;
    end
  endtask

  // Waits for a rising edge of clk_out[ch], then counts one full high+low period.
  task automatic measure(input int ch, output int hi, output int lo, output int ticks);
    int   n = 0;
    logic prev;
    hi = 0; lo = 0; ticks = 0;
    prev = clk_out[ch];
    forever begin
      @(negedge clk);
      n++;
      if (!prev && clk_out[ch]) break;
      prev = clk_out[ch];
      if (n > 200) break;
    end
    if (n > 200) begin
      timeout("measure_rise");
      return;
    end
    while (clk_out[ch] && hi < 100) begin
      hi++;
      ticks += int'(tick[ch]);
      @(negedge clk);
    end
    while (!clk_out[ch] && lo < 100) begin
      lo++;
      ticks += int'(tick[ch]);
      @(negedge clk);
    end
  endtask

  task automatic sb_check(input int ch, input int hi, input int lo, input int ticks);
    exp_t e;
    if (sb.size() == 0) begin
      timeout("scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    check("sb_channel", ch, e.ch);
    check("sb_high_cycles", hi, e.hi);
    check("sb_low_cycles", lo, e.lo);
    check("sb_ticks_per_period", ticks, 1);
  endtask

  initial begin
    int       n, hi, lo, tk, stall;
    logic [3:0] prev;

    vecs[0] = '{ch: 1, dv: 5, exp_hi: 3, exp_lo: 2};
    vecs[1] = '{ch: 0, dv: 4, exp_hi: 2, exp_lo: 2};
    vecs[2] = '{ch: 2, dv: 3, exp_hi: 2, exp_lo: 1};
    vecs[3] = '{ch: 0, dv: 0, exp_hi: 1, exp_lo: 1};
    vecs[4] = '{ch: 2, dv: 1, exp_hi: 1, exp_lo: 1};

    areset    = 1'b1;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
    ch_en     = 4'hF;

    // Reset state.
    #50;
    check("rst_clk_out", int'(clk_out), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_cfg_ready", int'(cfg_ready), 1);
    #50;
    areset = 1'b0;

    // Lock after exactly LOCK_CYCLES edges following release.
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      n++;
      #1;
      if (locked) break;
    end
    check("lock_after_reset_edges", n, 64);

    // Default divisor 2: every output toggles each cycle, tick on the low half.
    @(negedge clk);
    prev = clk_out;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("def_toggle", int'(clk_out), int'(4'(~prev)));
      check("def_tick", int'(tick), int'(4'(~clk_out)));
      prev = clk_out;
    end

    // Table-driven reprogramming.
    for (int v = 0; v < 5; v++) begin
      do_cfg(vecs[v].ch, vecs[v].dv, stall);
      sb.push_back('{ch: vecs[v].ch, hi: vecs[v].exp_hi, lo: vecs[v].exp_lo});
      check("vec_ready_low_pending", int'(cfg_ready), 0);
      check("vec_locked_drop", int'(locked), 0);
      wait_ready();
      count_to_lock(n);
      check("vec_relock_cycles", n, 64);
      measure(vecs[v].ch, hi, lo, tk);
      sb_check(vecs[v].ch, hi, lo, tk);
    end

    // Out-of-range channel: accepted and dropped, lock untouched.
    cfg_valid = 1'b1;
    cfg_ch    = 3'd7;
    cfg_div   = 16'd9;
    @(negedge clk);
    check("badch_ready", int'(cfg_ready), 1);
    check("badch_locked", int'(locked), 1);
    cfg_valid = 1'b0;
    @(negedge clk);
    check("badch_locked_after", int'(locked), 1);

    // Disabled channel: load applies next cycle, first period full length on enable.
    ch_en[3] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("dis_clk_out", int'(clk_out[3]), 0);
    check("dis_tick", int'(tick[3]), 0);
    do_cfg(3, 10, stall);
    sb.push_back('{ch: 3, hi: 5, lo: 5});
    check("dis_pending", int'(cfg_ready), 0);
    @(negedge clk);
    check("dis_apply_next_cycle", int'(cfg_ready), 1);
    ch_en[3] = 1'b1;
    @(negedge clk);
    check("dis_reenable_high", int'(clk_out[3]), 1);
    hi = 0; lo = 0; tk = 0;
    while (clk_out[3] && hi < 100) begin
      hi++;
      tk += int'(tick[3]);
      @(negedge clk);
    end
    while (!clk_out[3] && lo < 100) begin
      lo++;
      tk += int'(tick[3]);
      @(negedge clk);
    end
    sb_check(3, hi, lo, tk);

    // Back-to-back requests: the second stalls until the first applies.
    do_cfg(0, 6, stall);
    sb.push_back('{ch: 0, hi: 3, lo: 3});
    do_cfg(1, 4, stall);
    sb.push_back('{ch: 1, hi: 2, lo: 2});
    check("b2b_stalled", int'(stall > 0), 1);
    wait_ready();
    measure(0, hi, lo, tk);
    sb_check(0, hi, lo, tk);
    measure(1, hi, lo, tk);
    sb_check(1, hi, lo, tk);

    // Reset while a config is pending on the slow channel.
    do_cfg(3, 5, stall);
    check("mid_pending", int'(cfg_ready), 0);
    areset = 1'b1;
    #1;
    check("mid_rst_clk_out", int'(clk_out), 0);
    check("mid_rst_tick", int'(tick), 0);
    check("mid_rst_locked", int'(locked), 0);
    check("mid_rst_cfg_ready", int'(cfg_ready), 1);
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    sb.push_back('{ch: 3, hi: 1, lo: 1});
    @(negedge clk);
    check("post_rst_first_edge", int'(clk_out), 15);
    @(negedge clk);
    check("post_rst_second_edge", int'(clk_out), 0);
    check("post_rst_tick", int'(tick), 15);
    check("post_rst_locked", int'(locked), 0);
    measure(3, hi, lo, tk);
    sb_check(3, hi, lo, tk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
